// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the IF stage: fetch FSM encoding, reset/bubble defaults
// and PC arithmetic helpers.
package instruction_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_SQUASH = 2'd2,
        ST_HOLD   = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
    localparam logic [63:0] RESET_PC_DEF  = 64'h0;
    localparam logic [63:0] PC_INC        = 64'd4;

    function automatic logic [63:0] align_word(input logic [63:0] addr);
        return addr & ~64'd3;
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction-memory req/ack bus between the IF stage (master) and memory (slave).
interface instruction_fetch_if;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/instruction_fetch_if_id_register.sv
// IF/ID pipeline register: flush beats load, otherwise contents are held.
module instruction_fetch_if_id_register
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic        flush,
    input  logic [31:0] d_instr,
    input  logic [63:0] d_pc,
    input  logic [63:0] d_link,
    output logic [31:0] instruction,
    output logic [63:0] pc_out,
    output logic [63:0] link_out,
    output logic        valid
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            instruction <= NOP_INSTR;
            pc_out      <= '0;
            link_out    <= '0;
            valid       <= 1'b0;
        end else if (flush) begin
            instruction <= NOP_INSTR;
            pc_out      <= '0;
            link_out    <= '0;
            valid       <= 1'b0;
        end else if (load) begin
            instruction <= d_instr;
            pc_out      <= d_pc;
            link_out    <= d_link;
            valid       <= 1'b1;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: PC, req/ack fetch FSM with skid and squash handling, IF/ID register.
// Define FETCH_PERF_EN to add the fetched/squashed/stall saturating counters.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic                IF_ID_Flush,
    input  logic                Branchreg,
    input  logic [63:0]         PC_CB,
    input  logic [63:0]         branch_reg_target,
    instruction_fetch_if.master imem,
    output logic [31:0]         instruction,
    output logic [63:0]         PC_out_IF_ID,
    output logic [63:0]         PC_branch_link_out,
    output logic                if_id_valid
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]         fetched_cnt,
    output logic [31:0]         squashed_cnt,
    output logic [31:0]         stall_cnt
`endif
);

    fetch_state_t state, state_d;
    logic [63:0]  pc, pc_d;
    logic [63:0]  stale_addr, stale_d;
    logic [31:0]  skid_instr;
    logic [63:0]  skid_pc;
    logic         skid_we;
    logic         ifid_load, ifid_flush, ifid_from_skid;
    logic         req_c;
    logic [63:0]  addr_c;
    logic         redirect;
    logic [63:0]  branch_target, redirect_pc;
    logic [31:0]  ifid_instr_d;
    logic [63:0]  ifid_pc_d;

    assign redirect      = branch_taken | IF_ID_Flush;
    assign branch_target = Branchreg ? branch_reg_target : PC_CB;
    // A flush without a taken branch re-fetches from the current pc.
    assign redirect_pc   = branch_taken ? align_word(branch_target) : pc;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d        = state;
        pc_d           = pc;
        stale_d        = stale_addr;
        skid_we        = 1'b0;
        ifid_load      = 1'b0;
        ifid_flush     = 1'b0;
        ifid_from_skid = 1'b0;
        req_c          = 1'b0;
        addr_c         = pc;
        case (state)
            ST_IDLE: begin
                state_d = ST_FETCH;
                if (redirect) begin
                    pc_d       = redirect_pc;
                    ifid_flush = 1'b1;
                end
            end
            ST_FETCH: begin
                req_c = 1'b1;
                if (redirect) begin
                    ifid_flush = 1'b1;
                    pc_d       = redirect_pc;
                    // The outstanding request must still complete; remember its address.
                    if (!imem.imem_ack) begin
                        stale_d = pc;
                        state_d = ST_SQUASH;
                    end
                end else if (imem.imem_ack && !stall) begin
                    ifid_load = 1'b1;
                    pc_d      = pc + PC_INC;
                end else if (imem.imem_ack) begin
                    skid_we = 1'b1;
                    state_d = ST_HOLD;
                end else if (!stall) begin
                    ifid_flush = 1'b1;
                end
            end
            ST_SQUASH: begin
                req_c  = 1'b1;
                addr_c = stale_addr;
                if (redirect)      pc_d    = redirect_pc;
                if (imem.imem_ack) state_d = ST_FETCH;
            end
            ST_HOLD: begin
                if (redirect) begin
                    ifid_flush = 1'b1;
                    pc_d       = redirect_pc;
                    state_d    = ST_FETCH;
                end else if (!stall) begin
                    ifid_load      = 1'b1;
                    ifid_from_skid = 1'b1;
                    pc_d           = pc + PC_INC;
                    state_d        = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc         <= RESET_PC;
            stale_addr <= '0;
            skid_instr <= '0;
            skid_pc    <= '0;
        end else begin
            pc         <= pc_d;
            stale_addr <= stale_d;
            if (skid_we) begin
                skid_instr <= imem.imem_rdata;
                skid_pc    <= pc;
            end
        end
    end

    assign imem.imem_req  = req_c;
    assign imem.imem_addr = addr_c;

    assign ifid_instr_d = ifid_from_skid ? skid_instr : imem.imem_rdata;
    assign ifid_pc_d    = ifid_from_skid ? skid_pc : pc;

    instruction_fetch_if_id_register #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clock       (clock),
        .reset       (reset),
        .load        (ifid_load),
        .flush       (ifid_flush),
        .d_instr     (ifid_instr_d),
        .d_pc        (ifid_pc_d),
        .d_link      (ifid_pc_d + PC_INC),
        .instruction (instruction),
        .pc_out      (PC_out_IF_ID),
        .link_out    (PC_branch_link_out),
        .valid       (if_id_valid)
    );

`ifdef FETCH_PERF_EN
    logic fetch_ev, squash_ev;

    assign fetch_ev  = ifid_load;
    assign squash_ev = (state == ST_FETCH  && redirect && imem.imem_ack) ||
                       (state == ST_SQUASH && imem.imem_ack) ||
                       (state == ST_HOLD   && redirect);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetched_cnt  <= '0;
            squashed_cnt <= '0;
            stall_cnt    <= '0;
        end else begin
            if (fetch_ev  && fetched_cnt  != '1) fetched_cnt  <= fetched_cnt + 32'd1;
            if (squash_ev && squashed_cnt != '1) squashed_cnt <= squashed_cnt + 32'd1;
            if (stall     && stall_cnt    != '1) stall_cnt    <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- IF stage of the 5-stage ARMv8 pipeline; producer side of the IF/ID interface that instruction_decode consumes.
- Owns the PC, issues requests to instruction memory over a req/ack handshake and holds the IF/ID pipeline register.
- Honours hazard-unit stall, branch redirect (PC-relative or register target) and IF/ID flush from ID.
- Provides the ID stage with instruction, PC_out_IF_ID and the BL link value.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, bubble word; decodes to all-zero control.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- stall  in  1  hazard unit; hold the PC and IF/ID register
- branch_taken  in  1  branch resolved taken in ID (or_out)
- IF_ID_Flush  in  1  squash the IF/ID contents
- Branchreg  in  1  target select: 1 = branch_reg_target, 0 = PC_CB
- PC_CB  in  64  PC-relative branch target
- branch_reg_target  in  64  BR target (read_data1)
- imem_req  out  1  fetch request
- imem_addr  out  64  fetch address
- imem_ack  in  1  response valid this cycle
- imem_rdata  in  32  fetched word
- instruction  out  32  IF/ID instruction
- PC_out_IF_ID  out  64  IF/ID PC
- PC_branch_link_out  out  64  IF/ID PC+4, used as the BL link value
- if_id_valid  out  1  IF/ID holds a real instruction

Behaviour:
- Reset (async, active low) sets:
  - pc = RESET_PC and state = IDLE.
  - instruction = NOP_INSTR and if_id_valid = 0.
  - PC_out_IF_ID = 0, PC_branch_link_out = 0 and imem_req = 0.
  - Skid register cleared.
- Reset mid-transaction abandons any outstanding request. The memory must tolerate an imem_req drop.
- Handshake:
  - imem_req and imem_addr(=pc) stay stable until imem_ack is sampled high.
  - imem_rdata is valid only in the ack cycle.
  - A memory with imem_ack tied to 1 gives 1 instruction/cycle.
- Redirect = branch_taken | IF_ID_Flush.
  - Target = Branchreg ? branch_reg_target : PC_CB, with bits [1:0] forced to 0.
  - IF_ID_Flush without branch_taken flushes IF/ID only; pc is unchanged.
- Priority: reset > redirect > stall > normal.
- States:
  - IDLE: first cycle after reset. imem_req = 0. Next state FETCH.
  - FETCH: imem_req = 1.
    - Redirect: IF/ID <= NOP with valid = 0; pc <= target. If ack this cycle, discard the data and stay in FETCH; otherwise go to SQUASH.
    - ack and !stall: instruction <= rdata, PC_out_IF_ID <= pc, PC_branch_link_out <= pc+4, valid <= 1, pc <= pc+4.
    - ack and stall: rdata and pc go into the skid register; IF/ID held; go to HOLD.
    - No ack and !stall: IF/ID <= NOP with valid = 0 (bubble).
    - No ack and stall: IF/ID held.
  - SQUASH: imem_req = 1, addressed to the stale address held in a separate register.
    - On ack, discard the data and go to FETCH at the new pc.
    - A further redirect updates pc only.
  - HOLD: imem_req = 0.
    - !stall: skid contents move to IF/ID, pc += 4, go to FETCH.
    - Redirect: skid discarded, IF/ID <= NOP, pc <= target, go to FETCH.
- Redirect and stall in the same cycle: redirect wins.
- Arithmetic: 64-bit, modulo 2^64. PC+4 wraps from 64'hFFFF_FFFF_FFFF_FFFC to 0 silently.
- Latency: address to IF/ID is 1 cycle after ack. The taken-branch penalty is 1 bubble with a single-cycle memory.

Optional Feature:
- FETCH_PERF_EN:
  - When defined, adds 32-bit saturating counters fetched_cnt, squashed_cnt and stall_cnt as outputs.
  - fetched_cnt counts IF/ID loads with valid = 1.
  - squashed_cnt counts discarded acks and discarded skid entries.
  - stall_cnt counts cycles with stall = 1.
  - All three counters are cleared by reset.
- Without the macro: no counter ports and no counter logic.

Decomposition:
- Shared package holds:
  - The fetch state encoding (IDLE/FETCH/SQUASH/HOLD, 2 bits).
  - NOP_INSTR default.
  - RESET_PC default.
  - PC_INC = 64'd4.
- One natural sub-module: if_id_register, which holds instruction, PC, link PC and valid, with load/flush/hold controls. The existing n_mux serves the target select.

Test Plan:
- Reset with RESET_PC = 0 and ack tied to 1 -> addresses 0, 4, 8 on consecutive cycles; IF/ID PC lags by 1; valid goes high on the 2nd edge after reset release.
- Hold stall for 3 cycles while ack = 1 at pc = 8 -> word for 8 kept in skid; IF/ID unchanged; after release IF/ID = word@8 and the next address is 12.
- branch_taken with Branchreg = 0, PC_CB = 0x100 -> next address 0x100; one IF/ID bubble (NOP, valid = 0).
- Ack delayed 3 cycles at pc = 0x20, redirect to 0x200 in cycle 1 -> address stays 0x20 until ack; data discarded; then address 0x200.
- Branchreg = 1, branch_reg_target = 0x403 -> address 0x400. Separately, pc = 0xFFFF_FFFF_FFFF_FFFC -> next address 0.
- reset low during HOLD -> all outputs return to reset values immediately (async); fetch resumes at RESET_PC.
